mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 194 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit between a pipeline request port and a single-ported data memory.
// Sub-word stores use read-modify-write; misaligned or illegal-size requests complete with an error.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_data_in,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [31:0]           mem_data_out,
  input  logic                  mem_stall
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_DATA,
    WR,
    RMW_RD,
    RMW_MERGE,
    RMW_WR,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic                  write_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           merged_q;
  logic [31:0]           rdata_q;
  logic                  err_q;

  logic                  accept;
  logic                  req_bad;
  logic [1:0]            lane;

  // Alignment rules: halfwords on even bytes, words on word boundaries, size 11 never legal.
  function automatic logic is_bad(input logic [1:0] size, input logic [1:0] low);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = low[0];
      SIZE_WORD: bad = (low != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic        sgn,
                                               input logic [1:0]  byte_lane);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {byte_lane, 3'b000};
    case (size)
      SIZE_BYTE: res = {{24{sgn & sh[7]}}, sh[7:0]};
      SIZE_HALF: res = {{16{sgn & sh[15]}}, sh[15:0]};
      default:   res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  byte_lane);
    logic [31:0] mask;
    logic [31:0] data;
    mask = (size == SIZE_BYTE) ? (32'h0000_00FF << {byte_lane, 3'b000})
                               : (32'h0000_FFFF << {byte_lane, 3'b000});
    data = wdata << {byte_lane, 3'b000};
    return (word & ~mask) | (data & mask);
  endfunction

  assign accept  = req_valid && (state_q == IDLE);
  assign req_bad = is_bad(req_size, req_addr[1:0]);
  assign lane    = addr_q[1:0];

  // NOTE: state is held in flops written only with non-blocking assignments, so every
  // always_ff reads the pre-edge value of its neighbours regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_bad)                     state_d = RESP;
          else if (!req_write)             state_d = RD;
          else if (req_size == SIZE_WORD)  state_d = WR;
          else                             state_d = RMW_RD;
        end
      end
      RD:        if (!mem_stall) state_d = RD_DATA;
      RD_DATA:   state_d = RESP;
      WR:        if (!mem_stall) state_d = RESP;
      RMW_RD:    if (!mem_stall) state_d = RMW_MERGE;
      RMW_MERGE: state_d = RMW_WR;
      RMW_WR:    if (!mem_stall) state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Request fields are captured only at accept, so the memory address stays put for the whole request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q  <= 1'b0;
      size_q   <= SIZE_BYTE;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        write_q  <= req_write;
        size_q   <= req_size;
        signed_q <= req_signed;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        err_q    <= req_bad;
        rdata_q  <= '0;
      end
      if (state_q == RD_DATA) begin
        rdata_q <= load_extract(mem_data_out, size_q, signed_q, lane);
      end
      if (state_q == RMW_MERGE) begin
        merged_q <= store_merge(mem_data_out, wdata_q, size_q, lane);
      end
    end
  end

  // Memory strobes come from state alone; read and write states are disjoint.
  always_comb begin
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_err     = 1'b0;
    rsp_rdata   = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_data_in = '0;
    case (state_q)
      IDLE:   req_ready = 1'b1;
      RD:     mem_read  = 1'b1;
      RMW_RD: mem_read  = 1'b1;
      WR: begin
        mem_write   = 1'b1;
        mem_data_in = wdata_q;
      end
      RMW_WR: begin
        mem_write   = 1'b1;
        mem_data_in = merged_q;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = (err_q || write_q) ? 32'h0 : rdata_q;
      end
      default: ;
    endcase
  end

  assign mem_address = addr_q[ADDR_WIDTH+1:2];

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a synchronous memory model, a driver that pushes
// expected responses into a scoreboard, and a monitor that checks each rsp_valid pulse.
module tb_mem_access_unit;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_write, req_signed;
  logic [1:0]    req_size;
  logic [AW+1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid, rsp_err;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_data_in, mem_data_out;
  logic          mem_write, mem_read, mem_stall;

  mem_access_unit #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_write(mem_write),
    .mem_read(mem_read), .mem_data_out(mem_data_out), .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  logic [31:0] mem [0:255];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_read || mem_write) acc_cnt <= acc_cnt + 1;

  // Synchronous memory: a read returns data the cycle after a non-stalled mem_read.
  always @(posedge clk) begin
    if (mem_write && !mem_stall) mem[mem_address[7:0]] <= mem_data_in;
    if (mem_read && !mem_stall)  mem_data_out <= mem[mem_address[7:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      check("mem_rw_exclusive", {31'b0, mem_read & mem_write}, 32'h0);
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid with no request outstanding (t=%0t)", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
          check("rsp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Returns #1 after the accept edge. rsp_valid is expected in the cycle ending at edge
  // accept+lat, i.e. seen at the negedge where cyc == accept + lat - 1.
  task automatic issue(input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [AW+1:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input int lat, input bit push);
    exp_t e;
    @(negedge clk);
    check("req_ready", {31'b0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (push) begin
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.cyc   = cyc + lat - 1;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: %0d responses still outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic req(input logic wr, input logic [1:0] size, input logic sgn,
                     input logic [AW+1:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err, input int lat);
    issue(wr, size, sgn, addr, wdata, exp_rdata, exp_err, lat, 1'b1);
    wait_done();
  endtask

  int acc_before;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[5]       = 32'h1122_3344;
    mem_data_out = 32'h0;
    mem_stall    = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_signed   = 1'b0;
    req_addr     = '0;
    req_wdata    = 32'h0;
    rst_n        = 1'b0;

    // Reset values while rst_n is held low.
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'h1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_mem_read", {31'b0, mem_read}, 32'h0);
    check("rst_mem_write", {31'b0, mem_write}, 32'h0);
    check("rst_mem_address", {16'h0, mem_address}, 32'h0);
    check("rst_mem_data_in", mem_data_in, 32'h0);
    rst_n = 1'b1;

    // Word store: write strobe in the first cycle after accept, response two cycles after accept.
    issue(1'b1, 2'b10, 1'b0, 18'h0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1'b1);
    @(negedge clk);
    check("wst_mem_write", {31'b0, mem_write}, 32'h1);
    check("wst_mem_address", {16'h0, mem_address}, 32'h4);
    check("wst_mem_data_in", mem_data_in, 32'hDEAD_BEEF);
    wait_done();
    check("wst_mem4", mem[4], 32'hDEAD_BEEF);

    // Loads of every size and sign mode from 0xDEADBEEF.
    req(1'b0, 2'b00, 1'b1, 18'h0013, 32'h0, 32'hFFFF_FFDE, 1'b0, 3);
    req(1'b0, 2'b00, 1'b0, 18'h0013, 32'h0, 32'h0000_00DE, 1'b0, 3);
    req(1'b0, 2'b00, 1'b1, 18'h0011, 32'h0, 32'hFFFF_FFBE, 1'b0, 3);
    req(1'b0, 2'b01, 1'b1, 18'h0010, 32'h0, 32'hFFFF_BEEF, 1'b0, 3);
    req(1'b0, 2'b01, 1'b0, 18'h0012, 32'h0, 32'h0000_DEAD, 1'b0, 3);
    req(1'b0, 2'b10, 1'b1, 18'h0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);

    // Sub-word stores via read-modify-write.
    req(1'b1, 2'b01, 1'b0, 18'h0012, 32'h0000_1234, 32'h0, 1'b0, 4);
    check("hst_mem4", mem[4], 32'h1234_BEEF);
    req(1'b1, 2'b00, 1'b0, 18'h0011, 32'hFFFF_FF55, 32'h0, 1'b0, 4);
    check("bst_mem4", mem[4], 32'h1234_55EF);

    // Misaligned / illegal requests: one-cycle error, no memory access.
    acc_before = acc_cnt;
    req(1'b0, 2'b10, 1'b0, 18'h0011, 32'h0, 32'h0, 1'b1, 1);
    req(1'b1, 2'b01, 1'b0, 18'h0013, 32'hAAAA_AAAA, 32'h0, 1'b1, 1);
    req(1'b0, 2'b11, 1'b0, 18'h0010, 32'h0, 32'h0, 1'b1, 1);
    req(1'b1, 2'b10, 1'b0, 18'h0012, 32'h5555_5555, 32'h0, 1'b1, 1);
    check("err_no_access", acc_cnt, acc_before);
    check("err_mem4", mem[4], 32'h1234_55EF);

    // Three stall cycles during RD: read held at a constant address, response at accept+6.
    issue(1'b0, 2'b10, 1'b0, 18'h0010, 32'h0, 32'h1234_55EF, 1'b0, 6, 1'b1);
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_mem_read", {31'b0, mem_read}, 32'h1);
      check("stall_mem_address", {16'h0, mem_address}, 32'h4);
      @(posedge clk);
    end
    #1 mem_stall = 1'b0;
    wait_done();

    // A request held valid while busy must be ignored.
    issue(1'b0, 2'b10, 1'b0, 18'h0010, 32'h0, 32'h1234_55EF, 1'b0, 3, 1'b1);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'b10;
    req_addr  = 18'h0020;
    req_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("busy_mem_address", {16'h0, mem_address}, 32'h4);
    @(posedge clk);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_done();
    repeat (3) @(posedge clk);
    check("busy_mem8", mem[8], 32'h0);

    // Reset during RMW_MERGE aborts with no response and leaves memory untouched.
    issue(1'b1, 2'b00, 1'b0, 18'h0015, 32'h0000_00AA, 32'h0, 1'b0, 4, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_req_ready", {31'b0, req_ready}, 32'h1);
    check("abort_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("abort_mem_read", {31'b0, mem_read}, 32'h0);
    check("abort_mem_write", {31'b0, mem_write}, 32'h0);
    check("abort_mem_address", {16'h0, mem_address}, 32'h0);
    check("abort_mem_data_in", mem_data_in, 32'h0);
    check("abort_rsp_rdata", rsp_rdata, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    check("abort_mem5", mem[5], 32'h1122_3344);

    // Unit still works after the abort.
    req(1'b0, 2'b00, 1'b0, 18'h0015, 32'h0, 32'h0000_0033, 1'b0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
